audio_in_deserializer: RTL

- I2S receive path of the audio controller. It is the ADC-side counterpart of the DAC serializer and its bit counter.
- Consumes the same single-cycle bit-clock and LR-clock edge strobes, and samples serial_audio_in_data on bit-clock rising edges.
- Assembles left/right samples MSB-first and pushes each completed stereo pair into a small first-word-fall-through FIFO.
- The FIFO is read by the controller's bus interface.

---
 rtl/audio_in_deserializer_if.sv | 34 +++
 rtl/audio_in_deserializer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/audio_in_deserializer_if.sv
// Read-side bus of the I2S receive path: FIFO head, status and pop/flush.
// The controller's bus interface is the master; the deserializer is the slave.
interface audio_in_deserializer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
);
  logic                          read_en;
  logic                          clear_fifo;
  logic [DATA_WIDTH-1:0]         left_channel_data;
  logic [DATA_WIDTH-1:0]         right_channel_data;
  logic                          data_valid;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;

  modport master (
    output read_en,
    output clear_fifo,
    input  left_channel_data,
    input  right_channel_data,
    input  data_valid,
    input  fifo_count,
    input  overflow
  );

  modport slave (
    input  read_en,
    input  clear_fifo,
    output left_channel_data,
    output right_channel_data,
    output data_valid,
    output fifo_count,
    output overflow
  );
endinterface

// File: rtl/audio_in_deserializer.sv
// I2S ADC receive path: slot capture FSM feeding a FWFT stereo-pair FIFO.
// Define AUDIO_IN_LEFT_JUSTIFIED_EN to capture left-justified frames.
module audio_in_deserializer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_clk_rising_edge,
  input  logic bit_clk_falling_edge,
  input  logic left_right_clk_rising_edge,
  input  logic left_right_clk_falling_edge,
  input  logic serial_audio_in_data,
  audio_in_deserializer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef logic [CW-1:0] bcnt_t;

  localparam cnt_t  FULL_CNT = cnt_t'(FIFO_DEPTH);
  localparam bcnt_t BITS     = bcnt_t'(DATA_WIDTH);
  localparam bcnt_t LAST_BIT = bcnt_t'(1);

  localparam logic [1:0] IDLE  = 2'd0;
`ifndef AUDIO_IN_LEFT_JUSTIFIED_EN
  localparam logic [1:0] DELAY = 2'd1;
`endif
  localparam logic [1:0] SHIFT = 2'd2;

  logic [1:0]            state;
  logic                  channel;
  logic [DATA_WIDTH-2:0] shift_reg;
  bcnt_t                 bit_cnt;
  logic [DATA_WIDTH-1:0] left_hold;
  logic                  left_valid;
  logic [DATA_WIDTH-1:0] left_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] right_mem [FIFO_DEPTH];
  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  cnt_t                  count;
  logic                  overflow_flag;

  logic                  lr_edge;
  logic                  word_done;
  logic                  push_req;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [DATA_WIDTH-1:0] word;

  assign lr_edge   = left_right_clk_rising_edge
                   | left_right_clk_falling_edge;
  assign word      = {shift_reg, serial_audio_in_data};
  assign word_done = (state == SHIFT) && bit_clk_rising_edge
                   && !lr_edge && (bit_cnt == LAST_BIT);
  assign push_req  = word_done && channel && left_valid;
  assign full      = (count == FULL_CNT);
  assign pop       = bus.read_en && (count != '0);
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  // slot tracking, delay slot and MSB-first shifting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      channel   <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (lr_edge) begin
      channel   <= left_right_clk_rising_edge;
      shift_reg <= '0;
`ifdef AUDIO_IN_LEFT_JUSTIFIED_EN
      state     <= SHIFT;
      bit_cnt   <= BITS;
`else
      state     <= DELAY;
      bit_cnt   <= '0;
`endif
    end else if (bit_clk_rising_edge) begin
      case (state)
`ifndef AUDIO_IN_LEFT_JUSTIFIED_EN
        DELAY: begin
          state   <= SHIFT;
          bit_cnt <= BITS;
        end
`endif
        SHIFT: begin
          shift_reg <= word[DATA_WIDTH-2:0];
          bit_cnt   <= bit_cnt - LAST_BIT;
          if (bit_cnt == LAST_BIT) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // left word holding register; a new left slot invalidates the old word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_hold  <= '0;
      left_valid <= 1'b0;
    end else begin
      if (word_done && !channel) left_hold <= word;
      if (bus.clear_fifo || left_right_clk_falling_edge)
        left_valid <= 1'b0;
      else if (word_done)
        left_valid <= !channel;
    end
  end

  // stereo-pair FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow_flag <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        left_mem[i]  <= '0;
        right_mem[i] <= '0;
      end
    end else if (bus.clear_fifo) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow_flag <= 1'b0;
    end else begin
      if (push) begin
        left_mem[wr_ptr]  <= left_hold;
        right_mem[wr_ptr] <= word;
        wr_ptr            <= wr_ptr + ptr_t'(1);
      end
      if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
      if (push && !pop)
        count <= count + cnt_t'(1);
      else if (pop && !push)
        count <= count - cnt_t'(1);
      if (drop) overflow_flag <= 1'b1;
    end
  end

  assign bus.left_channel_data  = left_mem[rd_ptr];
  assign bus.right_channel_data = right_mem[rd_ptr];
  assign bus.data_valid         = (count != '0);
  assign bus.fifo_count         = count;
  assign bus.overflow           = overflow_flag;

  // the bit clock cannot rise and fall in the same cycle
  assert property (@(posedge clk) disable iff (!reset)
    !(bit_clk_rising_edge && bit_clk_falling_edge));

endmodule
